// File: rtl/ncl_ring_sim.sv
// ---------------------------------------------------------------------------
// ncl_ring_sim
//
// Purpose:
//   Cycle-level model of a NULL Convention Logic ring of 1-of-N stages. Each
//   clock models one gate delay. Every stage is a row of C-elements, one per
//   rail. A stage's input is the previous stage's rails. Its enable is the
//   inverted completion of the next stage. One stage (ROT_STAGE) rotates the
//   rails by one position, so the DATA value changes on every lap of the ring.
//   A small observer on stage 0 reports each new wavefront.
//
// Parameters:
//   RAILS      - rails per stage (2..8)
//   STAGES     - stages in the ring (3..16)
//   ROT_STAGE  - index of the stage that rotates rail k to rail k+1
//   DATA_STAGE - stage that holds DATA (rail 0) after initialisation
//
// Ports:
//   clk         in   rising-edge clock (one gate delay per cycle)
//   init_n      in   synchronous active-low ring initialise
//   stall       in   freezes stage state, counters and monitor registers
//   stage_rails out  registered rails, stage i at [i*RAILS +: RAILS]
//   comp        out  per-stage completion (OR of that stage's rails)
//   wave_valid  out  one-cycle pulse when stage 0 goes NULL->DATA
//   wave_rail   out  hot rail index of stage 0 while wave_valid is high
//   wave_count  out  stage-0 wavefronts since init, wraps at 16 bits
//   period      out  unstalled cycles between the last two wavefronts
//   code_err    out  sticky flag set when any stage is multi-hot
//
// Configuration:
//   NCL_RING_MON_EN - when defined, builds the period/code_err monitor.
//                     When undefined, period and code_err are tied to 0.
// ---------------------------------------------------------------------------
module ncl_ring_sim #(
   parameter int RAILS      = 3,
   parameter int STAGES     = 4,
   parameter int ROT_STAGE  = 0,
   parameter int DATA_STAGE = STAGES - 1
) (
   input  logic                      clk,
   input  logic                      init_n,
   input  logic                      stall,
   output logic [STAGES*RAILS-1:0]   stage_rails,
   output logic [STAGES-1:0]         comp,
   output logic                      wave_valid,
   output logic [2:0]                wave_rail,
   output logic [15:0]               wave_count,
   output logic [15:0]               period,
   output logic                      code_err
);

   logic [RAILS-1:0] rails_q [STAGES];
   logic [RAILS-1:0] rails_d [STAGES];
   logic             new_wave;
   logic [2:0]       hot_idx;

   // Stage i listens to stage i-1, and stage 0 wraps back to the last stage.
   // Stage i may only change when stage i+1 has finished with the opposite
   // phase. Each rail is a C-element: it goes to 1 when both input and enable
   // are 1. It goes to 0 when both are 0. Otherwise it holds its value. The
   // majority form below implements that hold behaviour.
   genvar g;
   generate
      for (g = 0; g < STAGES; g++) begin : g_stage
         localparam int PREV = (g == 0) ? STAGES - 1 : g - 1;
         localparam int NEXT = (g + 1) % STAGES;
         logic [RAILS-1:0] in_raw;
         logic [RAILS-1:0] in_rot;
         logic [RAILS-1:0] en;

         assign in_raw = rails_q[PREV];

         if (g == ROT_STAGE) begin : g_rot
            assign in_rot = {in_raw[RAILS-2:0], in_raw[RAILS-1]};
         end else begin : g_pass
            assign in_rot = in_raw;
         end

         assign en          = {RAILS{~comp[NEXT]}};
         assign rails_d[g]  = (in_rot & en) | (rails_q[g] & (in_rot | en));
         assign comp[g]     = |rails_q[g];
         assign stage_rails[g*RAILS +: RAILS] = rails_q[g];
      end
   endgenerate

   // Stage 0 is about to receive a new wavefront when it is NULL now and
   // will hold some DATA after this edge. The index encoder picks the lowest
   // hot rail. For a legal one-hot code, that is the only hot rail.
   always_comb begin
      new_wave = ~comp[0] & (|rails_d[0]);
      hot_idx  = '0;
      for (int k = RAILS - 1; k >= 0; k--) begin
         if (rails_d[0][k]) begin
            hot_idx = 3'(k);
         end
      end
   end

   // Ring state and wavefront observer. Initialisation beats stall. A stalled
   // edge freezes the ring and the counter. It also drops the wave_valid
   // pulse, so a stall never stretches the pulse into a second wavefront.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         for (int i = 0; i < STAGES; i++) begin
            rails_q[i] <= (i == DATA_STAGE) ? RAILS'(1) : '0;
         end
         wave_valid <= 1'b0;
         wave_rail  <= '0;
         wave_count <= '0;
      end else if (stall) begin
         wave_valid <= 1'b0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            rails_q[i] <= rails_d[i];
         end
         wave_valid <= new_wave;
         if (new_wave) begin
            wave_rail  <= hot_idx;
            wave_count <= wave_count + 16'd1;
         end
      end
   end

`ifdef NCL_RING_MON_EN
   logic [15:0]       gap_cnt;
   logic [15:0]       gap_inc;
   logic [STAGES-1:0] multi_hot;

   // A stage is multi-hot when clearing its lowest set bit still leaves a
   // bit set.
   generate
      for (g = 0; g < STAGES; g++) begin : g_mon
         assign multi_hot[g] = |(rails_q[g] & (rails_q[g] - RAILS'(1)));
      end
   endgenerate

   // This is the gap counter, including the edge that produces the wavefront.
   // It saturates so that a very long gap reads as the maximum value instead
   // of wrapping.
   always_comb begin
      gap_inc = (gap_cnt == 16'hffff) ? gap_cnt : gap_cnt + 16'd1;
   end

   // The monitor counts only unstalled edges. On each wavefront it latches
   // the gap into period. code_err is sticky until the next initialise.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         gap_cnt  <= '0;
         period   <= '0;
         code_err <= 1'b0;
      end else if (!stall) begin
         if (new_wave) begin
            period  <= gap_inc;
            gap_cnt <= '0;
         end else begin
            gap_cnt <= gap_inc;
         end
         if (|multi_hot) begin
            code_err <= 1'b1;
         end
      end
   end
`else
   assign period   = '0;
   assign code_err = 1'b0;
`endif

endmodule

// File: doc/ncl_ring_sim.md
NCL_RING_SIM -- requirements
Module: ncl_ring_sim

Interface
REQ-001 Parameter RAILS, default 3, number of rails per 1-of-N stage (legal 2..8).
REQ-002 Parameter STAGES, default 4, number of pipeline stages in the ring (legal 3..16).
REQ-003 Parameter ROT_STAGE, default 0, index of the single stage that rotates rails.
REQ-004 Parameter DATA_STAGE, default STAGES-1, index of the stage holding the initial DATA wavefront.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock; one clock models one gate delay.
REQ-007 init_n  input  1  synchronous active-low ring initialise.
REQ-008 stall  input  1  when high, all stage state, counters and monitor registers hold.
REQ-009 stage_rails  output  STAGES*RAILS  registered rails; stage i occupies bits [i*RAILS +: RAILS].
REQ-010 comp  output  STAGES  per-stage completion: OR of that stage's rails.
REQ-011 wave_valid  output  1  one-cycle pulse when stage 0 goes NULL->DATA.
REQ-012 wave_rail  output  3  index of the hot rail of stage 0, valid while wave_valid is high.
REQ-013 wave_count  output  16  count of stage-0 NULL->DATA transitions since reset.
REQ-014 period  output  16  cycles between the last two stage-0 wavefronts (monitor only, REQ-029).
REQ-015 code_err  output  1  sticky flag: some stage held more than one hot rail (monitor only).

Function
REQ-016 NULL = all rails 0; DATA = exactly one rail 1; all stages update simultaneously from previous-cycle state.
REQ-017 enable_i = ~comp[(i+1) mod STAGES]; input_i = rails of stage (i-1) mod STAGES, wrapping stage 0 from stage STAGES-1.
REQ-018 At ROT_STAGE, input rail k maps to rail (k+1) mod RAILS before the stage's C-element; at all other stages input passes unchanged.
REQ-019 Per rail, C-element: input 1 and enable 1 -> rail 1; input 0 and enable 0 -> rail 0; otherwise hold.
REQ-020 comp and all stage outputs come directly from registers and carry no combinational path from inputs.
REQ-021 wave_valid is registered, high in the cycle stage_rails shows stage 0 newly DATA; wave_rail is the binary index of the hot rail.
REQ-022 wave_count increments by 1 per wave_valid and wraps 65535 -> 0.
REQ-023 With stall high the ring freezes completely; releasing stall resumes with no lost or duplicated wavefront.
REQ-024 stall asserted in the same cycle as a transition suppresses that transition and its wave_valid; the transition occurs on the first unstalled edge.

Reset
REQ-025 init_n low at a clock edge: all stages NULL except DATA_STAGE = rail 0 only; wave_valid, wave_count, period and code_err all 0.
REQ-026 init_n low takes priority over stall and takes effect mid-operation on the next edge, discarding all in-flight wavefronts.
REQ-027 The first edge with init_n high evaluates per REQ-016..REQ-019 from the reset state.

Configuration
REQ-028 Macro NCL_RING_MON_EN compiles in the monitor logic.
REQ-029 With NCL_RING_MON_EN defined: period records unstalled cycles from the previous wave_valid to the current one, saturating at 65535; code_err sets when any stage is multi-hot and clears only on reset.
REQ-030 Without NCL_RING_MON_EN: period and code_err are tied to 0 and no monitor registers exist; all other behaviour is identical.

Verification
REQ-031 Defaults, reset release, no stall -> stage_rails per cycle 1..5 = [010,000,000,001], [010,010,000,000], [000,010,010,000], [000,000,010,010], [100,000,000,010] (stage0 first).
REQ-032 Defaults, run 40 cycles -> wave_valid at cycles 1,5,9,... with wave_rail 1,2,0,1,...; wave_count = 10; period = 4 with monitor enabled.
REQ-033 stall held high cycles 3..7 -> stage_rails frozen at the cycle-2 value; sequence resumes from cycle 8 offset by 5; no extra wave_valid.
REQ-034 init_n low at cycle 6 for 1 cycle -> state returns to [000,000,000,001] and wave_count = 0; the sequence then restarts as in REQ-031.
REQ-035 RAILS=4, STAGES=6, 200 cycles -> exactly one DATA wavefront in the ring at all times, wave_rail cycles 1,2,3,0, and code_err stays 0.
REQ-036 Build without NCL_RING_MON_EN, rerun REQ-032 -> identical stage_rails, wave_valid and wave_count; period = 0 and code_err = 0.
